axi_ar_rr_scheduler: RTL and testbench

- Shares one AXI read-address channel between NUM_M requesting masters, e.g. IM and DM ports feeding the AR clock-domain-crossing wrapper.
- Grants one master at a time using round-robin arbitration.
- Registers the winner's AR fields and presents them downstream.
- Holds the channel until the matching R burst completes (RLAST handshake), so at most one read is outstanding.
- Checks the R beat count against the granted ARLEN.

---
 rtl/axi_sched_pkg.sv | 60 ++++++
 rtl/axi_ar_rr_scheduler_rr_pick.sv | 36 +++
 rtl/axi_ar_rr_scheduler.sv | 149 ++++++++++++++
 tb/tb_axi_ar_rr_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sched_pkg.sv
// ---------------------------------------------------------------------------
// axi_sched_pkg : shared types, widths and round-robin helper for AXI schedulers
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

package axi_sched_pkg;

  localparam int c_AXI_ID_BITS   = `AXI_ID_BITS;
  localparam int c_AXI_ADDR_BITS = `AXI_ADDR_BITS;
  localparam int c_AXI_LEN_BITS  = `AXI_LEN_BITS;
  localparam int c_AXI_SIZE_BITS = `AXI_SIZE_BITS;
  localparam int c_MAX_M         = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } rr_pick_t;

  // Scanned from the farthest offset down so the closest requester to ptr wins.
  function automatic rr_pick_t next_rr(input logic [1:0] ptr,
                                       input logic [c_MAX_M-1:0] req,
                                       input int num_m);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = c_MAX_M - 1; k >= 0; k--) begin
      if (k < num_m) begin
        j = (int'(ptr) + k) % num_m;
        if (req[j]) begin
          r.vld = 1'b1;
          r.idx = 2'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_ar_rr_scheduler_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : combinational round-robin winner select from a pointer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import axi_sched_pkg::*;
#(
  parameter int NUM_M    = 2,
  parameter int MID_BITS = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0]    i_req,
  input  logic [MID_BITS-1:0] i_ptr,
  output logic [MID_BITS-1:0] o_idx,
  output logic                o_any
);

  logic [c_MAX_M-1:0] w_req;
  logic [1:0]         w_ptr;
  rr_pick_t           w_pick;

  always_comb begin
    w_req                  = '0;
    w_req[NUM_M-1:0]       = i_req;
    w_ptr                  = '0;
    w_ptr[MID_BITS-1:0]    = i_ptr;
    w_pick                 = next_rr(w_ptr, w_req, NUM_M);
  end

  assign o_idx = w_pick.idx[MID_BITS-1:0];
  assign o_any = w_pick.vld;

endmodule

`default_nettype wire

// File: rtl/axi_ar_rr_scheduler.sv
// ---------------------------------------------------------------------------
// axi_ar_rr_scheduler : round-robin sharing of one AXI AR channel, one read in flight
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axi_ar_rr_scheduler
  import axi_sched_pkg::*;
#(
  parameter int NUM_M     = 2,
  parameter int ID_BITS   = c_AXI_ID_BITS,
  parameter int ADDR_BITS = c_AXI_ADDR_BITS,
  parameter int LEN_BITS  = c_AXI_LEN_BITS,
  parameter int SIZE_BITS = c_AXI_SIZE_BITS,
  parameter int MID_BITS  = $clog2(NUM_M)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_M*ID_BITS-1:0]     ARID_M,
  input  logic [NUM_M*ADDR_BITS-1:0]   ARADDR_M,
  input  logic [NUM_M*LEN_BITS-1:0]    ARLEN_M,
  input  logic [NUM_M*SIZE_BITS-1:0]   ARSIZE_M,
  input  logic [NUM_M*2-1:0]           ARBURST_M,
  input  logic [NUM_M-1:0]             ARVALID_M,
  output logic [NUM_M-1:0]             ARREADY_M,
  output logic [MID_BITS+ID_BITS-1:0]  ARID_S,
  output logic [ADDR_BITS-1:0]         ARADDR_S,
  output logic [LEN_BITS-1:0]          ARLEN_S,
  output logic [SIZE_BITS-1:0]         ARSIZE_S,
  output logic [1:0]                   ARBURST_S,
  output logic                         ARVALID_S,
  input  logic                         ARREADY_S,
  input  logic                         RVALID_S,
  input  logic                         RREADY_S,
  input  logic                         RLAST_S,
  output logic                         busy,
  output logic [MID_BITS-1:0]          grant_idx,
  output logic                         err_len
);

  sched_state_t                  r_state;
  logic [MID_BITS-1:0]           r_rr_ptr;
  logic [MID_BITS-1:0]           r_grant_idx;
  logic [LEN_BITS:0]             r_beat_cnt;
  logic                          r_err_len;
  logic [MID_BITS+ID_BITS-1:0]   r_arid;
  logic [ADDR_BITS-1:0]          r_araddr;
  logic [LEN_BITS-1:0]           r_arlen;
  logic [SIZE_BITS-1:0]          r_arsize;
  logic [1:0]                    r_arburst;
  logic                          r_arvalid;

  logic [MID_BITS-1:0]           w_win_idx;
  logic                          w_win_any;
  logic                          w_r_hs;
  logic                          w_cnt_at_len;
  logic [NUM_M-1:0]              w_arready;
  logic [MID_BITS-1:0]           w_ptr_next;

  rr_pick #(
    .NUM_M    (NUM_M),
    .MID_BITS (MID_BITS)
  ) u_rr_pick (
    .i_req (ARVALID_M),
    .i_ptr (r_rr_ptr),
    .o_idx (w_win_idx),
    .o_any (w_win_any)
  );

  assign w_r_hs       = RVALID_S & RREADY_S;
  assign w_cnt_at_len = (r_beat_cnt == {1'b0, r_arlen});
  assign w_ptr_next   = (r_grant_idx == MID_BITS'(NUM_M - 1)) ? '0 : r_grant_idx + 1'b1;

  // The address handshake to a master is only offered from IDLE and never under reset.
  always_comb begin
    w_arready = '0;
    if (!reset && (r_state == ST_IDLE) && w_win_any) begin
      w_arready[w_win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_beat_cnt  <= '0;
      r_err_len   <= 1'b0;
      r_arid      <= '0;
      r_araddr    <= '0;
      r_arlen     <= '0;
      r_arsize    <= '0;
      r_arburst   <= '0;
      r_arvalid   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_any) begin
            r_arid      <= {w_win_idx, ARID_M[w_win_idx*ID_BITS +: ID_BITS]};
            r_araddr    <= ARADDR_M[w_win_idx*ADDR_BITS +: ADDR_BITS];
            r_arlen     <= ARLEN_M[w_win_idx*LEN_BITS +: LEN_BITS];
            r_arsize    <= ARSIZE_M[w_win_idx*SIZE_BITS +: SIZE_BITS];
            r_arburst   <= ARBURST_M[w_win_idx*2 +: 2];
            r_grant_idx <= w_win_idx;
            r_arvalid   <= 1'b1;
            r_state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (ARREADY_S) begin
            r_arvalid  <= 1'b0;
            r_rr_ptr   <= w_ptr_next;
            r_beat_cnt <= '0;
            r_state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_r_hs) begin
            // beat_cnt holds the number of earlier beats, so the last beat sees ARLEN.
            if (RLAST_S) begin
              if (!w_cnt_at_len) r_err_len <= 1'b1;
              r_state <= ST_IDLE;
            end else if (w_cnt_at_len) begin
              r_err_len <= 1'b1;
              r_state   <= ST_IDLE;
            end else if (r_beat_cnt != '1) begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ARREADY_M = w_arready;
  assign ARID_S    = r_arid;
  assign ARADDR_S  = r_araddr;
  assign ARLEN_S   = r_arlen;
  assign ARSIZE_S  = r_arsize;
  assign ARBURST_S = r_arburst;
  assign ARVALID_S = r_arvalid;
  assign busy      = (r_state != ST_IDLE);
  assign grant_idx = r_grant_idx;
  assign err_len   = r_err_len;

endmodule

`default_nettype wire

// File: tb/tb_axi_ar_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_axi_ar_rr_scheduler : directed table, corner sequences and random transactions
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_axi_ar_rr_scheduler;

  localparam int NUM_M     = 2;
  localparam int ID_BITS   = 4;
  localparam int ADDR_BITS = 32;
  localparam int LEN_BITS  = 4;
  localparam int SIZE_BITS = 3;
  localparam int MID_BITS  = 1;

  logic                         clock = 1'b0;
  logic                         reset = 1'b1;
  logic [NUM_M*ID_BITS-1:0]     ARID_M;
  logic [NUM_M*ADDR_BITS-1:0]   ARADDR_M;
  logic [NUM_M*LEN_BITS-1:0]    ARLEN_M;
  logic [NUM_M*SIZE_BITS-1:0]   ARSIZE_M;
  logic [NUM_M*2-1:0]           ARBURST_M;
  logic [NUM_M-1:0]             ARVALID_M;
  logic [NUM_M-1:0]             ARREADY_M;
  logic [MID_BITS+ID_BITS-1:0]  ARID_S;
  logic [ADDR_BITS-1:0]         ARADDR_S;
  logic [LEN_BITS-1:0]          ARLEN_S;
  logic [SIZE_BITS-1:0]         ARSIZE_S;
  logic [1:0]                   ARBURST_S;
  logic                         ARVALID_S;
  logic                         ARREADY_S;
  logic                         RVALID_S, RREADY_S, RLAST_S;
  logic                         busy;
  logic [MID_BITS-1:0]          grant_idx;
  logic                         err_len;

  always #5 clock = ~clock;

  axi_ar_rr_scheduler #(
    .NUM_M(NUM_M), .ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS),
    .LEN_BITS(LEN_BITS), .SIZE_BITS(SIZE_BITS), .MID_BITS(MID_BITS)
  ) dut (
    .clock(clock), .reset(reset),
    .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
    .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S), .RLAST_S(RLAST_S),
    .busy(busy), .grant_idx(grant_idx), .err_len(err_len)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [ID_BITS-1:0]   m_id    [NUM_M];
  logic [ADDR_BITS-1:0] m_addr  [NUM_M];
  logic [LEN_BITS-1:0]  m_len   [NUM_M];
  logic [SIZE_BITS-1:0] m_size  [NUM_M];
  logic [1:0]           m_burst [NUM_M];

  typedef struct {
    logic [NUM_M-1:0] req;
    logic [3:0]       len;
    int               last;   // beat carrying RLAST, 0 = never
    int               grant;
    logic             err;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fields();
    for (int i = 0; i < NUM_M; i++) begin
      ARID_M[i*ID_BITS +: ID_BITS]       = m_id[i];
      ARADDR_M[i*ADDR_BITS +: ADDR_BITS] = m_addr[i];
      ARLEN_M[i*LEN_BITS +: LEN_BITS]    = m_len[i];
      ARSIZE_M[i*SIZE_BITS +: SIZE_BITS] = m_size[i];
      ARBURST_M[i*2 +: 2]                = m_burst[i];
    end
  endtask

  task automatic check_s_fields(input int g, input string tag);
    chk({tag, "/arvalid_s"}, 64'(ARVALID_S), 64'd1);
    chk({tag, "/arid_s"},    64'(ARID_S),    64'({MID_BITS'(g), m_id[g]}));
    chk({tag, "/araddr_s"},  64'(ARADDR_S),  64'(m_addr[g]));
    chk({tag, "/arlen_s"},   64'(ARLEN_S),   64'(m_len[g]));
    chk({tag, "/arsize_s"},  64'(ARSIZE_S),  64'(m_size[g]));
    chk({tag, "/arburst_s"}, 64'(ARBURST_S), 64'(m_burst[g]));
    chk({tag, "/arready_m0"}, 64'(ARREADY_M), 64'd0);
  endtask

  // One full read: grant, address phase with rdy_dly stall cycles, then the R burst.
  task automatic run_txn(input logic [NUM_M-1:0] req, input int last_beat, input int rdy_dly,
                         input int exp_g, input logic exp_err, input string tag);
    int nb;
    int w;
    nb = (last_beat != 0) ? last_beat : int'(m_len[exp_g]) + 1;
    drive_fields();
    ARVALID_M = req;
    #1;
    w = 0;
    while (ARREADY_M == '0 && w < 8) begin
      @(negedge clock); #1;
      w++;
    end
    chk({tag, "/arready_m"}, 64'(ARREADY_M), 64'(1) << exp_g);
    chk({tag, "/busy_idle"}, 64'(busy), 64'd0);
    if (ARREADY_M == '0) begin
      ARVALID_M = '0;
      return;
    end
    @(negedge clock);
    ARVALID_M = '0;
    #1;
    check_s_fields(exp_g, tag);
    chk({tag, "/grant_idx"}, 64'(grant_idx), 64'(exp_g));
    chk({tag, "/busy_addr"}, 64'(busy), 64'd1);
    for (int d = 0; d < rdy_dly; d++) begin
      ARVALID_M = req;
      RVALID_S  = 1'b1; RREADY_S = 1'b1; RLAST_S = 1'b1;
      @(negedge clock); #1;
      check_s_fields(exp_g, {tag, "/stall"});
    end
    ARVALID_M = '0;
    RVALID_S  = 1'b0; RREADY_S = 1'b0; RLAST_S = 1'b0;
    ARREADY_S = 1'b1;
    @(negedge clock);
    ARREADY_S = 1'b0;
    #1;
    chk({tag, "/arvalid_s_low"}, 64'(ARVALID_S), 64'd0);
    chk({tag, "/busy_data"}, 64'(busy), 64'd1);
    for (int b = 1; b <= nb; b++) begin
      repeat ($urandom_range(0, 2)) begin
        RVALID_S = 1'($urandom_range(0, 1));
        RREADY_S = ~RVALID_S;
        RLAST_S  = 1'($urandom_range(0, 1));
        @(negedge clock);
      end
      RVALID_S = 1'b1; RREADY_S = 1'b1; RLAST_S = (b == last_beat);
      @(negedge clock);
      if (b < nb) chk({tag, "/busy_mid"}, 64'(busy), 64'd1);
    end
    RVALID_S = 1'b0; RREADY_S = 1'b0; RLAST_S = 1'b0;
    #1;
    chk({tag, "/busy_end"}, 64'(busy), 64'd0);
    chk({tag, "/arvalid_s_end"}, 64'(ARVALID_S), 64'd0);
    chk({tag, "/err_len"}, 64'(err_len), 64'(exp_err));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          ptr;
    logic        err_m;
    int          g;
    int          last;
    logic [NUM_M-1:0] req;

    tbl[0] = '{req: 2'b11, len: 4'd3, last: 4, grant: 0, err: 1'b0};
    tbl[1] = '{req: 2'b11, len: 4'd0, last: 1, grant: 1, err: 1'b0};
    tbl[2] = '{req: 2'b11, len: 4'd1, last: 2, grant: 0, err: 1'b0};
    tbl[3] = '{req: 2'b10, len: 4'd2, last: 3, grant: 1, err: 1'b0};
    tbl[4] = '{req: 2'b10, len: 4'd0, last: 1, grant: 1, err: 1'b0};
    tbl[5] = '{req: 2'b01, len: 4'd3, last: 2, grant: 0, err: 1'b1};
    tbl[6] = '{req: 2'b11, len: 4'd1, last: 2, grant: 1, err: 1'b1};
    tbl[7] = '{req: 2'b11, len: 4'd2, last: 0, grant: 0, err: 1'b1};

    ARID_M = '0; ARADDR_M = '0; ARLEN_M = '0; ARSIZE_M = '0; ARBURST_M = '0;
    ARREADY_S = 1'b0; RVALID_S = 1'b0; RREADY_S = 1'b0; RLAST_S = 1'b0;
    ARVALID_M = '1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    chk("reset/busy",      64'(busy),      64'd0);
    chk("reset/arvalid_s", 64'(ARVALID_S), 64'd0);
    chk("reset/arready_m", 64'(ARREADY_M), 64'd0);
    chk("reset/err_len",   64'(err_len),   64'd0);
    chk("reset/grant_idx", 64'(grant_idx), 64'd0);
    chk("reset/arid_s",    64'(ARID_S),    64'd0);
    chk("reset/araddr_s",  64'(ARADDR_S),  64'd0);
    ARVALID_M = '0;
    reset = 1'b0;
    @(negedge clock);

    // Single request from master 1, downstream ready one cycle after ARVALID_S.
    m_id[0] = 4'h3; m_addr[0] = 32'h0000_2000; m_len[0] = 4'd1; m_size[0] = 3'd2; m_burst[0] = 2'd1;
    m_id[1] = 4'hA; m_addr[1] = 32'h0001_0000; m_len[1] = 4'd3; m_size[1] = 3'd3; m_burst[1] = 2'd2;
    run_txn(2'b10, 4, 1, 1, 1'b0, "single");

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NUM_M; i++) begin
        m_id[i]    = 4'(r * 2 + i + 1);
        m_addr[i]  = 32'h1000_0000 + 32'(r * 16 + i * 4);
        m_len[i]   = (i == tbl[r].grant) ? tbl[r].len : (tbl[r].len ^ 4'd5);
        m_size[i]  = 3'(i + 1);
        m_burst[i] = 2'(i + 1);
      end
      run_txn(tbl[r].req, tbl[r].last, r % 3, tbl[r].grant, tbl[r].err, $sformatf("vec%0d", r));
    end

    // Long backpressure: fields must hold for 10 stalled cycles.
    m_len[0] = 4'd2; m_addr[0] = 32'hDEAD_BEE0; m_id[0] = 4'hC;
    run_txn(2'b01, 3, 10, 0, 1'b1, "backpressure");

    // Reset in the middle of a burst after 2 of 4 beats.
    m_len[0] = 4'd3;
    drive_fields();
    ARVALID_M = 2'b01;
    @(negedge clock);
    ARVALID_M = '0;
    ARREADY_S = 1'b1;
    @(negedge clock);
    ARREADY_S = 1'b0;
    RVALID_S = 1'b1; RREADY_S = 1'b1;
    repeat (2) @(negedge clock);
    RVALID_S = 1'b0; RREADY_S = 1'b0;
    #1;
    chk("midreset/busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clock); #1;
    chk("midreset/busy",      64'(busy),      64'd0);
    chk("midreset/arvalid_s", 64'(ARVALID_S), 64'd0);
    chk("midreset/err_len",   64'(err_len),   64'd0);
    chk("midreset/grant_idx", 64'(grant_idx), 64'd0);
    reset = 1'b0;
    m_len[0] = 4'd1; m_len[1] = 4'd2;
    run_txn(2'b11, 2, 0, 0, 1'b0, "after_reset_ptr");
    run_txn(2'b10, 3, 1, 1, 1'b0, "after_reset_m1");

    // Random traffic against a transaction-level round-robin / length model.
    ptr   = 0;
    err_m = 1'b0;
    for (int t = 0; t < 40; t++) begin
      req = NUM_M'($urandom_range(1, (1 << NUM_M) - 1));
      for (int i = 0; i < NUM_M; i++) begin
        m_id[i]    = ID_BITS'($urandom);
        m_addr[i]  = $urandom;
        m_len[i]   = LEN_BITS'($urandom_range(0, 7));
        m_size[i]  = SIZE_BITS'($urandom);
        m_burst[i] = 2'($urandom);
      end
      g = -1;
      for (int k = 0; k < NUM_M; k++) begin
        if (g < 0 && req[(ptr + k) % NUM_M]) g = (ptr + k) % NUM_M;
      end
      if ($urandom_range(0, 3) == 0) last = $urandom_range(0, int'(m_len[g]));
      else                           last = int'(m_len[g]) + 1;
      err_m = err_m | (last != int'(m_len[g]) + 1);
      ptr = (g + 1) % NUM_M;
      run_txn(req, last, $urandom_range(0, 3), g, err_m, $sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
